// File: rtl/mem_dump_unit.sv
// Post-halt memory dumper: reads WORDS words bytewise from BASE_ADDR and
// streams them out as big-endian packed words over a valid/ready port.
// Ports: clk, rst (sync, active-low), hcf (halt flag starts the dump),
//   mem_rd/mem_addr/mem_rdata (byte read port, data one cycle after rd),
//   out_valid/out_ready/out_data/out_offset (word stream), busy, dump_done.
module mem_dump_unit #(
  parameter logic [15:0] BASE_ADDR = 16'h8000,
  parameter int          WORDS     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hcf,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_offset,
  output logic        busy,
  output logic        dump_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [7:0] W_LAST = 8'(WORDS - 1);

  state_t      r_state;
  logic [7:0]  r_w;
  logic [1:0]  r_k;
  logic [31:0] r_data;
  logic        r_mem_rd;
  logic [15:0] r_mem_addr;
  logic        r_out_valid;
  logic [7:0]  r_out_offset;
  logic        r_busy;
  logic        r_done;

  logic [7:0]  w_w_inc;
  logic [1:0]  w_k_inc;
  logic [15:0] w_addr_cur;
  logic [15:0] w_addr_nxt;
  logic [15:0] w_addr_rd;

  // Address sums wrap naturally at 16 bits.
  assign w_w_inc    = r_w + 8'd1;
  assign w_k_inc    = r_k + 2'd1;
  assign w_addr_cur = BASE_ADDR + {6'd0, r_w, 2'b00};
  assign w_addr_nxt = BASE_ADDR + {6'd0, w_w_inc, 2'b00};
  assign w_addr_rd  = w_addr_cur + {14'd0, w_k_inc};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_w          <= 8'd0;
      r_k          <= 2'd0;
      r_data       <= 32'd0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= 16'd0;
      r_out_valid  <= 1'b0;
      r_out_offset <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (hcf) begin
            r_state    <= S_READ;
            r_w        <= 8'd0;
            r_k        <= 2'd0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= BASE_ADDR;
            r_busy     <= 1'b1;
          end
        end
        S_READ: begin
          // Byte k-1 returns while byte k is being requested.
          case (r_k)
            2'd1:    r_data[31:24] <= mem_rdata;
            2'd2:    r_data[23:16] <= mem_rdata;
            2'd3:    r_data[15:8]  <= mem_rdata;
            default: ;
          endcase
          if (r_k == 2'd3) begin
            r_state    <= S_CAPTURE;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= 16'd0;
          end else begin
            r_k        <= w_k_inc;
            r_mem_addr <= w_addr_rd;
          end
        end
        S_CAPTURE: begin
          r_data[7:0]  <= mem_rdata;
          r_state      <= S_SEND;
          r_out_valid  <= 1'b1;
          r_out_offset <= {r_w[5:0], 2'b00};
        end
        S_SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_w == W_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_READ;
              r_w        <= w_w_inc;
              r_k        <= 2'd0;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_addr_nxt;
            end
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_mem_addr;
  assign out_valid  = r_out_valid;
  assign out_data   = r_data;
  assign out_offset = r_out_offset;
  assign busy       = r_busy;
  assign dump_done  = r_done;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Testbench for mem_dump_unit: cycle-exact vector table, scoreboarded
// dumps under several ready/hcf policies, reset abort, address wrap.
module tb_mem_dump_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hcf, rdy;
  logic        mem_rd, out_valid, busy, dump_done;
  logic [15:0] mem_addr;
  logic [7:0]  rdata, out_offset;
  logic [31:0] out_data;

  logic        rst_b, hcf_b, rdy_b;
  logic        mem_rd_b, out_valid_b, busy_b, dump_done_b;
  logic [15:0] mem_addr_b;
  logic [7:0]  rdata_b, out_offset_b;
  logic [31:0] out_data_b;

  mem_dump_unit u_dut (
    .clk(clk), .rst(rst), .hcf(hcf),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(rdata),
    .out_valid(out_valid), .out_ready(rdy),
    .out_data(out_data), .out_offset(out_offset),
    .busy(busy), .dump_done(dump_done)
  );

  mem_dump_unit #(.BASE_ADDR(16'hFFFC), .WORDS(2)) u_wrap (
    .clk(clk), .rst(rst_b), .hcf(hcf_b),
    .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(rdata_b),
    .out_valid(out_valid_b), .out_ready(rdy_b),
    .out_data(out_data_b), .out_offset(out_offset_b),
    .busy(busy_b), .dump_done(dump_done_b)
  );

  logic [7:0] mem [0:65535];

  // Memory returns a poison byte when not read so mistimed captures show up.
  always @(posedge clk) begin
    rdata   <= mem_rd   ? mem[mem_addr]   : 8'hEE;
    rdata_b <= mem_rd_b ? mem[mem_addr_b] : 8'hEE;
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] first_word, last_word;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [15:0] base,
                                           input int i);
    logic [15:0] a;
    a = base + 16'(4 * i);
    return {mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3]};
  endfunction

  function automatic logic [59:0] outs0();
    return {mem_rd, mem_addr, out_valid, out_data, out_offset,
            busy, dump_done};
  endfunction

  task automatic fill_pattern();
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
  endtask

  task automatic do_reset0();
    rst = 1'b0; hcf = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'(outs0()), 64'd0);
    rst = 1'b1;
  endtask

  // Scoreboarded dump of the default instance (32 words from 0x8000).
  // rmode: 0 ready always, 1 random ready, 2 ready low 5 cycles per word.
  task automatic run_dump(input int rmode, input bit hold);
    logic [31:0] expq [$];
    logic [31:0] pd;
    logic [7:0]  po;
    int idx, cyc, stall;
    bit prev_stall, prev_valid;
    for (int i = 0; i < 32; i++) expq.push_back(exp_word(16'h8000, i));
    idx = 0; cyc = 0; stall = 0;
    prev_stall = 0; prev_valid = 0; pd = '0; po = '0;
    hcf = 1'b1;
    while (idx < 32 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (!hold) hcf = 1'b0;
      if (prev_stall)
        chk("stall_hold", {out_valid, out_data, out_offset},
            {1'b1, pd, po});
      chk("rd_during_valid", 64'(mem_rd && out_valid), 64'd0);
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && !prev_valid) stall = 5;
          if (stall > 0) begin rdy = 1'b0; stall--; end
          else rdy = 1'b1;
        end
      endcase
      if (out_valid && rdy) begin
        chk($sformatf("word%0d_data", idx), out_data, expq[idx]);
        chk($sformatf("word%0d_off", idx), out_offset, 8'(4 * idx));
        if (idx == 0) first_word = out_data;
        last_word = out_data;
        idx++;
      end
      prev_stall = out_valid && !rdy;
      prev_valid = out_valid;
      pd = out_data; po = out_offset;
    end
    if (idx < 32) chk("dump_timeout", idx, 32);
    @(negedge clk);
    chk("done_state", {dump_done, busy, out_valid, mem_rd}, 4'b1000);
    hcf = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("done_ignores_hcf", {mem_rd, busy, dump_done}, 3'b001);
    end
    hcf = 1'b0;
  endtask

  typedef struct {
    bit          hcf;
    bit          rdy;
    bit          e_rd;
    logic [15:0] e_addr;
    bit          e_valid;
    bit          e_busy;
    logic [31:0] e_data;
    logic [7:0]  e_off;
  } vec_t;

  vec_t vt [14];

  initial begin
    logic [15:0] aq [$];
    logic [31:0] wq [$];
    logic [7:0]  oq [$];
    logic [15:0] ea [8];
    bit seen;
    int n;

    rst = 1'b0; hcf = 1'b0; rdy = 1'b0;
    rst_b = 1'b0; hcf_b = 1'b0; rdy_b = 1'b0;
    fill_pattern();

    // Row: inputs applied before an edge, outputs expected after it.
    vt[0]  = '{1, 0, 1, 16'h8000, 0, 1, 0, 0};
    vt[1]  = '{0, 0, 1, 16'h8001, 0, 1, 0, 0};
    vt[2]  = '{0, 0, 1, 16'h8002, 0, 1, 0, 0};
    vt[3]  = '{0, 0, 1, 16'h8003, 0, 1, 0, 0};
    vt[4]  = '{0, 0, 0, 16'h0000, 0, 1, 0, 0};
    vt[5]  = '{0, 0, 0, 16'h0000, 1, 1, 32'h00010203, 8'd0};
    vt[6]  = '{0, 0, 0, 16'h0000, 1, 1, 32'h00010203, 8'd0};
    vt[7]  = '{0, 1, 1, 16'h8004, 0, 1, 0, 0};
    vt[8]  = '{0, 0, 1, 16'h8005, 0, 1, 0, 0};
    vt[9]  = '{0, 0, 1, 16'h8006, 0, 1, 0, 0};
    vt[10] = '{0, 0, 1, 16'h8007, 0, 1, 0, 0};
    vt[11] = '{0, 0, 0, 16'h0000, 0, 1, 0, 0};
    vt[12] = '{0, 0, 0, 16'h0000, 1, 1, 32'h04050607, 8'd4};
    vt[13] = '{0, 1, 1, 16'h8008, 0, 1, 0, 0};

    do_reset0();
    chk("wrap_reset_outs",
        {mem_rd_b, mem_addr_b, out_valid_b, out_data_b, out_offset_b,
         busy_b, dump_done_b}, 64'd0);

    for (int r = 0; r < 14; r++) begin
      hcf = vt[r].hcf; rdy = vt[r].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", r), {mem_rd, mem_addr, out_valid, busy},
          {vt[r].e_rd, vt[r].e_addr, vt[r].e_valid, vt[r].e_busy});
      if (vt[r].e_valid)
        chk($sformatf("vec%0d_word", r), {out_data, out_offset},
            {vt[r].e_data, vt[r].e_off});
    end

    do_reset0();
    run_dump(0, 1'b0);
    chk("pulse_first", first_word, 32'h00010203);
    chk("pulse_last", last_word, 32'h7C7D7E7F);

    do_reset0();
    run_dump(2, 1'b1);
    chk("stall_first", first_word, 32'h00010203);
    chk("stall_last", last_word, 32'h7C7D7E7F);

    // Abort during SEND of word 5, then restart with hcf already high.
    do_reset0();
    hcf = 1'b1; rdy = 1'b1; seen = 0; n = 0;
    while (!seen && n < 1000) begin
      @(negedge clk);
      n++;
      hcf = 1'b0;
      if (out_valid && out_offset == 8'd20) begin
        seen = 1; rdy = 1'b0;
      end
    end
    chk("word5_reached", seen, 1);
    chk("word5_data", out_data, 32'h14151617);
    rst = 1'b0; hcf = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_outs", 64'(outs0()), 64'd0);
    end
    rst = 1'b1;
    run_dump(0, 1'b1);
    chk("restart_first", first_word, 32'h00010203);

    for (int t = 0; t < 3; t++) begin
      do_reset0();
      for (int i = 0; i < 128; i++) mem[16'h8000 + i] = 8'($urandom);
      run_dump(1, 1'($urandom_range(0, 1)));
    end

    // Wrapping instance: BASE_ADDR 0xFFFC, two words.
    for (int i = 0; i < 4; i++) begin
      mem[16'hFFFC + i] = 8'($urandom);
      mem[i] = 8'($urandom);
    end
    ea = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF,
           16'h0000, 16'h0001, 16'h0002, 16'h0003};
    rst_b = 1'b1; hcf_b = 1'b1; rdy_b = 1'b1; n = 0;
    while (!dump_done_b && n < 200) begin
      @(negedge clk);
      n++;
      hcf_b = 1'b0;
      if (mem_rd_b) aq.push_back(mem_addr_b);
      if (out_valid_b && rdy_b) begin
        wq.push_back(out_data_b);
        oq.push_back(out_offset_b);
      end
    end
    chk("wrap_done", dump_done_b, 1);
    chk("wrap_nrd", aq.size(), 8);
    chk("wrap_nwords", wq.size(), 2);
    for (int i = 0; i < aq.size() && i < 8; i++)
      chk($sformatf("wrap_addr%0d", i), aq[i], ea[i]);
    for (int i = 0; i < wq.size() && i < 2; i++) begin
      chk($sformatf("wrap_word%0d", i), wq[i], exp_word(16'hFFFC, i));
      chk($sformatf("wrap_off%0d", i), oq[i], 8'(4 * i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dump_unit.md
MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

Interface
REQ-001 Parameter BASE_ADDR, default 16'h8000, byte address of first dumped byte.
REQ-002 Parameter WORDS, default 32, number of 32-bit words dumped (128 bytes); legal range 1..256.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 hcf  input  1  CPU halt flag (level); starts dump.
REQ-006 mem_rd  output  1  byte read strobe to data memory.
REQ-007 mem_addr  output  16  byte address for mem_rd.
REQ-008 mem_rdata  input  8  read byte; valid exactly one cycle after mem_rd.
REQ-009 out_valid  output  1  dump word available.
REQ-010 out_ready  input  1  consumer accepts word.
REQ-011 out_data  output  32  packed dump word.
REQ-012 out_offset  output  8  byte offset of word from BASE_ADDR (4*word index).
REQ-013 busy  output  1  dump in progress.
REQ-014 dump_done  output  1  all WORDS words transferred.

Function
REQ-015 States: IDLE, READ, CAPTURE, SEND, DONE.
REQ-016 IDLE: hcf=1 sampled -> READ with word index w=0, byte index k=0; else stay.
REQ-017 READ: mem_rd=1, mem_addr=BASE_ADDR+4*w+k; k increments each cycle; after k=3 -> CAPTURE.
REQ-018 Byte returned one cycle after read of byte k is latched into slot k; CAPTURE latches byte 3, then -> SEND.
REQ-019 Packing: out_data = {byte0, byte1, byte2, byte3} (byte0 = lowest address, in bits 31:24).
REQ-020 SEND: out_valid=1, out_offset=4*w; transfer occurs on cycle with out_valid&&out_ready.
REQ-021 out_data and out_offset stable while out_valid=1 and out_ready=0; out_valid never drops before transfer.
REQ-022 After transfer: w=WORDS-1 -> DONE, else w+1, k=0 -> READ on next cycle.
REQ-023 Per-word latency: hcf/transfer sampled at cycle t -> READ t+1..t+4, CAPTURE t+5, out_valid first high t+6.
REQ-024 DONE: dump_done=1, busy=0, out_valid=0, mem_rd=0; held until reset, hcf ignored.
REQ-025 busy=1 exactly in READ, CAPTURE, SEND.
REQ-026 hcf deassertion after dump start has no effect; dump runs to completion.
REQ-027 mem_rd=0 outside READ; mem_addr=16'h0000 when mem_rd=0.
REQ-028 Address arithmetic modulo 2^16; BASE_ADDR+4*WORDS overflow wraps, no error.
REQ-029 out_offset = 4*w truncated to 8 bits; WORDS=64 at offset 252 is last valid value.

Reset
REQ-030 rst=0 at any rising edge -> IDLE, w=0, k=0, data register 0, all outputs 0, next cycle.
REQ-031 Reset during READ/CAPTURE/SEND aborts dump; partially gathered word discarded, never presented.
REQ-032 After rst returns high with hcf already 1, dump starts from w=0 on first sampled edge.

Verification
REQ-033 Memory 0x8000..0x807F = byte value (addr & 0xFF), out_ready=1, pulse hcf -> 32 words, first out_data=32'h00010203 offset 0, last 32'h7C7D7E7F offset 124, dump_done high after 32nd transfer.
REQ-034 Same data, out_ready low 5 cycles whenever out_valid rises -> out_data/out_offset unchanged during stall, no dropped or duplicated words, mem_rd=0 during stall.
REQ-035 hcf held 1 for 1 cycle only vs held 1 forever -> identical word sequence; in DONE, hcf=1 causes no new mem_rd.
REQ-036 Assert rst=0 during SEND of word 5 (offset 20), release, hcf=1 -> outputs 0 during reset, new dump restarts at offset 0 with 32'h00010203.
REQ-037 Cycle check: hcf sampled at cycle 10, out_ready=1 -> mem_rd high cycles 11-14 at addrs 0x8000-0x8003, out_valid high cycle 16, second word mem_rd cycles 17-20.
REQ-038 BASE_ADDR=16'hFFFC, WORDS=2 -> reads 0xFFFC..0xFFFF then 0x0000..0x0003, offsets 0 and 4.
